// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - two-pass instruction sequencer in front of a combinational ALU
//
// Accepts one decoded instruction at a time and drives a combinational ALU
// (ALU_TOP) through one or two registered passes. Single-pass instructions
// return the ALU result directly. BRANCH, JAL and JALR use pass 1 for the
// control-transfer target and pass 2 for either the link value (PC+4) or the
// branch comparison.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   instruction handshake (in_ready high only in IDLE)
//   pc_in, rs1_in, rs2_in, imm_in, opcode, funct3, funct7   instruction fields
//   alu_pc, alu_rs1, alu_rs2, alu_imm, alu_opcode, alu_funct3, alu_funct7
//                         registered operands/fields driven to ALU_TOP
//   alu_result            combinational ALU_TOP output, sampled at pass end
//   out_valid / out_ready result bundle handshake
//   result                writeback value (ALU result or link PC+4)
//   br_target             control-transfer target, zero for other instructions
//   br_taken              control transfer taken
module alu_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   pc_in,
    input  logic [DATA_WIDTH-1:0]   rs1_in,
    input  logic [DATA_WIDTH-1:0]   rs2_in,
    input  logic [DATA_WIDTH-1:0]   imm_in,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    output logic [DATA_WIDTH-1:0]   alu_pc,
    output logic [DATA_WIDTH-1:0]   alu_rs1,
    output logic [DATA_WIDTH-1:0]   alu_rs2,
    output logic [DATA_WIDTH-1:0]   alu_imm,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [2:0]              alu_funct3,
    output logic [6:0]              alu_funct7,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [DATA_WIDTH-1:0]   br_target,
    output logic                    br_taken
);

    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JAL    = OPCODE_WIDTH'(7'b1101111);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = OPCODE_WIDTH'(7'b1100111);

    localparam logic [DATA_WIDTH-1:0] LINK_OFFSET = DATA_WIDTH'(32'd4);
    localparam logic [DATA_WIDTH-1:0] CLEAR_LSB   = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // Copy of the accepted instruction; the ALU drive registers are reused
    // for pass 2, so the original operands must be kept separately.
    logic [DATA_WIDTH-1:0]   cap_pc;
    logic [DATA_WIDTH-1:0]   cap_rs1;
    logic [DATA_WIDTH-1:0]   cap_rs2;
    logic [OPCODE_WIDTH-1:0] cap_opcode;
    logic [2:0]              cap_funct3;

    logic is_branch;
    logic is_jump;
    logic branch_decision;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign is_branch = (cap_opcode == OPC_BRANCH);
    assign is_jump   = (cap_opcode == OPC_JAL) || (cap_opcode == OPC_JALR);

    // Pass 2 of a branch leaves SUB (BEQ/BNE) or SLT/SLTU (the rest) on
    // alu_result; the branch outcome is read from it here.
    always_comb begin
        branch_decision = 1'b0;
        case (cap_funct3)
            3'b000:          branch_decision = (alu_result == '0);
            3'b001:          branch_decision = (alu_result != '0);
            3'b100, 3'b110:  branch_decision = alu_result[0];
            3'b101, 3'b111:  branch_decision = ~alu_result[0];
            default:         branch_decision = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_pc     <= '0;
            cap_rs1    <= '0;
            cap_rs2    <= '0;
            cap_opcode <= '0;
            cap_funct3 <= '0;
            alu_pc     <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_imm    <= '0;
            alu_opcode <= '0;
            alu_funct3 <= '0;
            alu_funct7 <= '0;
            result     <= '0;
            br_target  <= '0;
            br_taken   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_pc     <= pc_in;
                        cap_rs1    <= rs1_in;
                        cap_rs2    <= rs2_in;
                        cap_opcode <= opcode;
                        cap_funct3 <= funct3;
                        alu_pc     <= pc_in;
                        alu_rs1    <= rs1_in;
                        alu_rs2    <= rs2_in;
                        alu_imm    <= imm_in;
                        // JALR target is RS1+IMM, formed as an ADDI
                        if (opcode == OPC_JALR) begin
                            alu_opcode <= OPC_OP_IMM;
                            alu_funct3 <= 3'b000;
                            alu_funct7 <= 7'b0000000;
                        end else begin
                            alu_opcode <= opcode;
                            alu_funct3 <= funct3;
                            alu_funct7 <= funct7;
                        end
                        state <= PASS1;
                    end
                end

                PASS1: begin
                    if (is_branch || is_jump) begin
                        br_target <= (cap_opcode == OPC_JALR) ? (alu_result & CLEAR_LSB)
                                                               : alu_result;
                        if (is_branch) begin
                            alu_opcode <= OPC_OP;
                            alu_rs1    <= cap_rs1;
                            alu_rs2    <= cap_rs2;
                            case (cap_funct3[2:1])
                                2'b10: begin
                                    alu_funct3 <= 3'b010;
                                    alu_funct7 <= 7'b0000000;
                                end
                                2'b11: begin
                                    alu_funct3 <= 3'b011;
                                    alu_funct7 <= 7'b0000000;
                                end
                                default: begin
                                    alu_funct3 <= 3'b000;
                                    alu_funct7 <= 7'b0100000;
                                end
                            endcase
                        end else begin
                            // link value PC+4 as an ADDI on the captured PC
                            alu_opcode <= OPC_OP_IMM;
                            alu_funct3 <= 3'b000;
                            alu_funct7 <= 7'b0000000;
                            alu_rs1    <= cap_pc;
                            alu_imm    <= LINK_OFFSET;
                        end
                        state <= PASS2;
                    end else begin
                        result    <= alu_result;
                        br_target <= '0;
                        br_taken  <= 1'b0;
                        state     <= DONE;
                    end
                end

                PASS2: begin
                    if (is_branch) begin
                        result   <= '0;
                        br_taken <= branch_decision;
                    end else begin
                        result   <= alu_result;
                        br_taken <= 1'b1;
                    end
                    state <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural ALU_TOP
module tb_alu_sequencer;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in, rs1_in, rs2_in, imm_in;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result, br_target;
    logic        br_taken;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] pc, rs1, rs2, imm;
        logic [31:0] exp_res, exp_tgt;
        logic        exp_tk;
    } vec_t;

    vec_t vecs[13];

    alu_sequencer #(.DATA_WIDTH(32), .OPCODE_WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_pc(alu_pc), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .br_target(br_target), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    // Behavioural ALU_TOP: RV32I OP/OP_IMM arithmetic, PC+IMM for BRANCH/JAL,
    // IMM pass-through for anything else.
    function automatic logic [31:0] alu_fn(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] pc,
                                           input logic [31:0] a, input logic [31:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] b;
        if (opc == BRANCH || opc == JAL) return pc + imm;
        if (opc != OP && opc != OP_IMM) return imm;
        b = (opc == OP) ? rs2 : imm;
        case (f3)
            3'b000:  return (opc == OP && f7[5]) ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'd0, $signed(a) < $signed(b)};
            3'b011:  return {31'd0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_opcode, alu_funct3, alu_funct7, alu_pc, alu_rs1, alu_rs2, alu_imm);
    end

    // Instruction-level reference: what the sequenced bundle should contain.
    function automatic vec_t with_expect(input vec_t v);
        vec_t r = v;
        case (v.opc)
            BRANCH: begin
                r.exp_tgt = v.pc + v.imm;
                r.exp_res = 32'd0;
                case (v.f3)
                    3'b000:  r.exp_tk = (v.rs1 == v.rs2);
                    3'b001:  r.exp_tk = (v.rs1 != v.rs2);
                    3'b100:  r.exp_tk = ($signed(v.rs1) < $signed(v.rs2));
                    3'b101:  r.exp_tk = ($signed(v.rs1) >= $signed(v.rs2));
                    3'b110:  r.exp_tk = (v.rs1 < v.rs2);
                    3'b111:  r.exp_tk = (v.rs1 >= v.rs2);
                    default: r.exp_tk = 1'b0;
                endcase
            end
            JAL: begin
                r.exp_tgt = v.pc + v.imm;
                r.exp_res = v.pc + 32'd4;
                r.exp_tk  = 1'b1;
            end
            JALR: begin
                r.exp_tgt = (v.rs1 + v.imm) & ~32'd1;
                r.exp_res = v.pc + 32'd4;
                r.exp_tk  = 1'b1;
            end
            default: begin
                r.exp_tgt = 32'd0;
                r.exp_res = alu_fn(v.opc, v.f3, v.f7, v.pc, v.rs1, v.rs2, v.imm);
                r.exp_tk  = 1'b0;
            end
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic [31:0] er, input logic [31:0] et, input logic ek);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exp_res = er; v.exp_tgt = et; v.exp_tk = ek;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s actual=0x%08h required=0x%08h", tag, what, act, exp);
    endtask

    task automatic drive(input vec_t v);
        opcode = v.opc; funct3 = v.f3; funct7 = v.f7;
        pc_in = v.pc; rs1_in = v.rs1; rs2_in = v.rs2; imm_in = v.imm;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int exp_lat;
        exp_lat = (v.opc == BRANCH || v.opc == JAL || v.opc == JALR) ? 3 : 2;
        @(negedge clk);
        chk(tag, "in_ready", {31'd0, in_ready}, 32'd1);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = 99;
        chk(tag, "latency", 32'(lat), 32'(exp_lat));
        chk(tag, "result", result, v.exp_res);
        chk(tag, "br_target", br_target, v.exp_tgt);
        chk(tag, "br_taken", {31'd0, br_taken}, {31'd0, v.exp_tk});
        @(negedge clk);
        chk(tag, "out_valid_after", {31'd0, out_valid}, 32'd0);
        chk(tag, "in_ready_after", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int lat;

        vecs[0]  = mk(OP,     3'b000, 7'h00, 32'h0,        32'd5,        32'd7,        32'h0,        32'd12,       32'h0,    1'b0);
        vecs[1]  = mk(BRANCH, 3'b100, 7'h00, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        32'h120,  1'b1);
        vecs[2]  = mk(BRANCH, 3'b110, 7'h00, 32'h100,      32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        32'h120,  1'b0);
        vecs[3]  = mk(JALR,   3'b000, 7'h00, 32'h200,      32'h1001,     32'h0,        32'd4,        32'h204,      32'h1004, 1'b1);
        vecs[4]  = mk(JAL,    3'b000, 7'h00, 32'hFFFFFFFC, 32'h0,        32'h0,        32'd8,        32'h0,        32'h4,    1'b1);
        vecs[5]  = mk(OP,     3'b000, 7'h20, 32'h0,        32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 32'h0,    1'b0);
        vecs[6]  = mk(BRANCH, 3'b000, 7'h00, 32'h40,       32'd9,        32'd9,        32'hFFFFFFF0, 32'h0,        32'h30,   1'b1);
        vecs[7]  = mk(BRANCH, 3'b001, 7'h00, 32'h40,       32'd9,        32'd9,        32'hFFFFFFF0, 32'h0,        32'h30,   1'b0);
        vecs[8]  = mk(BRANCH, 3'b101, 7'h00, 32'h0,        32'd1,        32'hFFFFFFFF, 32'h8,        32'h0,        32'h8,    1'b1);
        vecs[9]  = mk(BRANCH, 3'b010, 7'h00, 32'h10,       32'd4,        32'd4,        32'h10,       32'h0,        32'h20,   1'b0);
        vecs[10] = mk(OP_IMM, 3'b000, 7'h00, 32'h0,        32'h10,       32'h0,        32'hFFFFFFFF, 32'hF,        32'h0,    1'b0);
        vecs[11] = mk(JALR,   3'b000, 7'h00, 32'h0,        32'h7,        32'h0,        32'h0,        32'h4,        32'h6,    1'b1);
        vecs[12] = mk(BRANCH, 3'b111, 7'h00, 32'h0,        32'd1,        32'hFFFFFFFF, 32'hC,        32'h0,        32'hC,    1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(vecs[0]);
        #1;
        chk("reset", "in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset", "out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset", "result", result, 32'd0);
        chk("reset", "br_target", br_target, 32'd0);
        chk("reset", "br_taken", {31'd0, br_taken}, 32'd0);
        chk("reset", "alu_rs1", alu_rs1, 32'd0);
        chk("reset", "alu_opcode", {25'd0, alu_opcode}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: v.opc = OP;
                1: v.opc = OP_IMM;
                2: v.opc = BRANCH;
                3: v.opc = JAL;
                4: v.opc = JALR;
                default: v.opc = LUI;
            endcase
            v.f3  = 3'($urandom_range(0, 7));
            v.f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            v.pc  = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFC : $urandom;
            v.rs1 = $urandom;
            v.rs2 = ($urandom_range(0, 3) == 0) ? v.rs1 : $urandom;
            v.imm = $urandom;
            v = with_expect(v);
            run_vec(v, $sformatf("rand%0d", i));
        end

        // Stall in DONE with a competing instruction presented throughout
        @(negedge clk);
        drive(vecs[0]);
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rs1_in = 32'hDEAD0000; rs2_in = 32'h1; opcode = OP_IMM;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("stall", "reached_done", {31'd0, out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("stall", "out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall", "in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall", "result", result, 32'd12);
            chk("stall", "alu_rs1", alu_rs1, 32'd5);
            @(negedge clk);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("stall", "out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("stall", "in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("stall", "alu_rs1_hold", alu_rs1, 32'd5);
        chk("stall", "alu_opcode_hold", {25'd0, alu_opcode}, {25'd0, OP});

        // Reset pulse during PASS2 of a BEQ
        @(negedge clk);
        drive(vecs[6]);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid", "pass2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid", "pass2_br_target", br_target, 32'h30);
        rst_n = 1'b0;
        #1;
        chk("rst_mid", "out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid", "in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid", "result", result, 32'd0);
        chk("rst_mid", "br_target", br_target, 32'd0);
        chk("rst_mid", "br_taken", {31'd0, br_taken}, 32'd0);
        chk("rst_mid", "alu_rs1", alu_rs1, 32'd0);
        chk("rst_mid", "alu_pc", alu_pc, 32'd0);
        chk("rst_mid", "alu_funct7", {25'd0, alu_funct7}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mid", "held_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], "post_reset_add");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
